// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per producer (RS, LSB), round-robin
// drain of at most one head per cycle onto a registered broadcast bus.
module cdb_arbiter #(
   parameter int unsigned LAB_W = 5,
   parameter int unsigned VAL_W = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             flush,
   input  logic             rs_valid,
   input  logic [LAB_W-1:0] rs_lab,
   input  logic [VAL_W-1:0] rs_val,
   output logic             rs_ready,
   input  logic             lsb_valid,
   input  logic [LAB_W-1:0] lsb_lab,
   input  logic [VAL_W-1:0] lsb_val,
   output logic             lsb_ready,
   output logic             cdb_en,
   output logic [LAB_W-1:0] cdb_lab,
   output logic [VAL_W-1:0] cdb_val,
   output logic             cdb_src
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = LAB_W + VAL_W;

   // index 0 = RS, index 1 = LSB
   logic [ENT_W-1:0]            mem [2][DEPTH];
   logic [1:0][PTR_W-1:0]       wr_ptr;
   logic [1:0][PTR_W-1:0]       rd_ptr;
   logic [1:0][CNT_W-1:0]       cnt;
   logic                        last_src;

   logic [1:0]                  full;
   logic [1:0]                  nonempty;
   logic [1:0]                  ready;
   logic [1:0]                  push;
   logic [1:0]                  pop;
   logic [1:0][ENT_W-1:0]       wdata;
   logic                        advance;
   logic                        grant;
   logic                        gnt_lsb;
   logic [ENT_W-1:0]            head;

   // Acceptance and grant decisions use only registered occupancy.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         full[i]     = (cnt[i] == CNT_W'(DEPTH));
         nonempty[i] = (cnt[i] != '0);
         ready[i]    = !full[i] && rdy_in && !flush && !rst_in;
      end
      wdata[0] = {rs_lab, rs_val};
      wdata[1] = {lsb_lab, lsb_val};
      push[0]  = rs_valid && ready[0];
      push[1]  = lsb_valid && ready[1];
      advance  = rdy_in && !flush;
      // last_src = 0 means RS won last time, so LSB takes a tie
      gnt_lsb  = nonempty[1] && (!nonempty[0] || !last_src);
      grant    = advance && (nonempty[0] || nonempty[1]);
      pop[0]   = grant && !gnt_lsb;
      pop[1]   = grant && gnt_lsb;
      head     = mem[gnt_lsb][rd_ptr[gnt_lsb]];
   end

   assign rs_ready  = ready[0];
   assign lsb_ready = ready[1];

   // Queue storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= wdata[i];
      end
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         last_src <= 1'b1;
         cdb_en   <= 1'b0;
         cdb_lab  <= '0;
         cdb_val  <= '0;
         cdb_src  <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         last_src <= 1'b1;
         cdb_en   <= 1'b0;
      end else if (rdy_in) begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            cnt[i] <= cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         end
         cdb_en <= grant;
         if (grant) begin
            cdb_lab  <= head[ENT_W-1:VAL_W];
            cdb_val  <= head[VAL_W-1:0];
            cdb_src  <= gnt_lsb;
            last_src <= gnt_lsb;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cdb_arbiter;

   localparam int unsigned LAB_W = 5;
   localparam int unsigned VAL_W = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned ENT_W = LAB_W + VAL_W;

   logic             clk = 1'b0;
   logic             rst_in;
   logic             rdy_in;
   logic             flush;
   logic             rs_valid;
   logic [LAB_W-1:0] rs_lab;
   logic [VAL_W-1:0] rs_val;
   logic             rs_ready;
   logic             lsb_valid;
   logic [LAB_W-1:0] lsb_lab;
   logic [VAL_W-1:0] lsb_val;
   logic             lsb_ready;
   logic             cdb_en;
   logic [LAB_W-1:0] cdb_lab;
   logic [VAL_W-1:0] cdb_val;
   logic             cdb_src;

   int total = 0;
   int bad   = 0;

   cdb_arbiter #(.LAB_W(LAB_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .rs_valid(rs_valid), .rs_lab(rs_lab), .rs_val(rs_val), .rs_ready(rs_ready),
      .lsb_valid(lsb_valid), .lsb_lab(lsb_lab), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
      .cdb_en(cdb_en), .cdb_lab(cdb_lab), .cdb_val(cdb_val), .cdb_src(cdb_src)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: two plain queues plus the broadcast register image.
   logic [ENT_W-1:0] mq [2][$];
   logic             m_en   = 1'b0;
   logic [LAB_W-1:0] m_lab  = '0;
   logic [VAL_W-1:0] m_val  = '0;
   logic             m_src  = 1'b0;
   logic             m_last = 1'b1;

   function automatic logic m_ready(input int i);
      return (mq[i].size() < DEPTH) && rdy_in && !flush && !rst_in;
   endfunction

   always @(posedge clk or posedge rst_in) begin : model
      bit r0, r1;
      int g;
      logic [ENT_W-1:0] e;
      if (rst_in) begin
         mq[0].delete(); mq[1].delete();
         m_en = 1'b0; m_lab = '0; m_val = '0; m_src = 1'b0; m_last = 1'b1;
      end else if (flush) begin
         mq[0].delete(); mq[1].delete();
         m_en = 1'b0; m_last = 1'b1;
      end else if (rdy_in) begin
         r0 = m_ready(0);
         r1 = m_ready(1);
         if (mq[0].size() > 0 && mq[1].size() > 0) g = m_last ? 0 : 1;
         else if (mq[0].size() > 0) g = 0;
         else if (mq[1].size() > 0) g = 1;
         else g = -1;
         if (g >= 0) begin
            e      = mq[g].pop_front();
            m_en   = 1'b1;
            m_lab  = e[ENT_W-1:VAL_W];
            m_val  = e[VAL_W-1:0];
            m_src  = (g == 1);
            m_last = (g == 1);
         end else begin
            m_en = 1'b0;
         end
         if (r0 && rs_valid)  mq[0].push_back({rs_lab, rs_val});
         if (r1 && lsb_valid) mq[1].push_back({lsb_lab, lsb_val});
      end
   end

   always @(negedge clk) begin : compare
      check("cdb_en",    64'(cdb_en),    64'(m_en));
      check("cdb_lab",   64'(cdb_lab),   64'(m_lab));
      check("cdb_val",   64'(cdb_val),   64'(m_val));
      check("cdb_src",   64'(cdb_src),   64'(m_src));
      check("rs_ready",  64'(rs_ready),  64'(m_ready(0)));
      check("lsb_ready", 64'(lsb_ready), 64'(m_ready(1)));
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   int  src_log[$];
   bit  saw_full;
   int  en_count;

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
      rs_valid = 1'b0; rs_lab = '0; rs_val = '0;
      lsb_valid = 1'b0; lsb_lab = '0; lsb_val = '0;
      repeat (2) cyc();
      check("reset_cdb_en", 64'(cdb_en), 64'd0);
      check("reset_cdb_val", 64'(cdb_val), 64'd0);
      check("reset_rs_ready", 64'(rs_ready), 64'd0);
      check("reset_lsb_ready", 64'(lsb_ready), 64'd0);
      rst_in = 1'b0;
      cyc();

      // single RS offer: two-cycle latency, one-cycle pulse
      rs_valid = 1'b1; rs_lab = LAB_W'(3); rs_val = 32'hDEAD;
      cyc();
      rs_valid = 1'b0;
      check("lat_edge0_en", 64'(cdb_en), 64'd0);
      cyc();
      check("lat_en", 64'(cdb_en), 64'd1);
      check("lat_lab", 64'(cdb_lab), 64'd3);
      check("lat_val", 64'(cdb_val), 64'hDEAD);
      check("lat_src", 64'(cdb_src), 64'd0);
      cyc();
      check("lat_pulse_end", 64'(cdb_en), 64'd0);

      // flush restores RS priority, then both producers offer every cycle
      flush = 1'b1; cyc(); flush = 1'b0;
      saw_full = 1'b0;
      for (int k = 0; k < 10; k++) begin
         rs_valid = 1'b1;  rs_lab = LAB_W'(k);      rs_val = 32'h100 + 32'(k);
         lsb_valid = 1'b1; lsb_lab = LAB_W'(16 + k); lsb_val = 32'h200 + 32'(k);
         cyc();
         if (cdb_en) src_log.push_back(int'(cdb_src));
         if (!rs_ready) saw_full = 1'b1;
      end
      rs_valid = 1'b0; lsb_valid = 1'b0;
      repeat (6) cyc();
      check("rr_count", 64'(src_log.size() >= 4), 64'd1);
      if (src_log.size() >= 4) begin
         check("rr_first_rs", 64'(src_log[0]), 64'd0);
         check("rr_second_lsb", 64'(src_log[1]), 64'd1);
         check("rr_third_rs", 64'(src_log[2]), 64'd0);
         check("rr_fourth_lsb", 64'(src_log[3]), 64'd1);
      end
      check("rr_ready_deassert", 64'(saw_full), 64'd1);

      // stall freezes every register including the broadcast pulse
      rs_valid = 1'b1; rs_lab = LAB_W'(1); rs_val = 32'h11;
      cyc();
      rs_lab = LAB_W'(2); rs_val = 32'h22;
      cyc();
      rs_valid = 1'b0; rdy_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("stall_en", 64'(cdb_en), 64'd1);
         check("stall_lab", 64'(cdb_lab), 64'd1);
         check("stall_ready", 64'(rs_ready), 64'd0);
      end
      rdy_in = 1'b1;
      cyc();
      check("stall_release_lab", 64'(cdb_lab), 64'd2);
      check("stall_release_en", 64'(cdb_en), 64'd1);
      cyc();
      check("stall_drained", 64'(cdb_en), 64'd0);

      // flush with both queues full and broadcast active, rdy_in low
      for (int k = 0; k < 6; k++) begin
         rs_valid = 1'b1;  rs_lab = LAB_W'(4 + k);  rs_val = 32'h300 + 32'(k);
         lsb_valid = 1'b1; lsb_lab = LAB_W'(20 + k); lsb_val = 32'h400 + 32'(k);
         cyc();
      end
      check("pre_flush_en", 64'(cdb_en), 64'd1);
      flush = 1'b1; rdy_in = 1'b0;
      #1;
      check("flush_rs_ready", 64'(rs_ready), 64'd0);
      cyc();
      flush = 1'b0; rdy_in = 1'b1; rs_valid = 1'b0; lsb_valid = 1'b0;
      #1;
      check("flush_en", 64'(cdb_en), 64'd0);
      check("flush_rs_ready_after", 64'(rs_ready), 64'd1);
      check("flush_lsb_ready_after", 64'(lsb_ready), 64'd1);
      en_count = 0;
      for (int k = 0; k < 5; k++) begin cyc(); if (cdb_en) en_count++; end
      check("flush_no_stale", 64'(en_count), 64'd0);

      // asynchronous reset between edges with entries queued
      for (int k = 0; k < 3; k++) begin
         rs_valid = 1'b1;  rs_lab = LAB_W'(10 + k); rs_val = 32'h500 + 32'(k);
         lsb_valid = 1'b1; lsb_lab = LAB_W'(26 + k); lsb_val = 32'h600 + 32'(k);
         cyc();
      end
      rs_valid = 1'b0; lsb_valid = 1'b0;
      check("pre_rst_en", 64'(cdb_en), 64'd1);
      #2 rst_in = 1'b1;
      #1;
      check("async_rst_en", 64'(cdb_en), 64'd0);
      check("async_rst_rs_ready", 64'(rs_ready), 64'd0);
      check("async_rst_lsb_ready", 64'(lsb_ready), 64'd0);
      repeat (2) cyc();
      rst_in = 1'b0;
      en_count = 0;
      for (int k = 0; k < 5; k++) begin cyc(); if (cdb_en) en_count++; end
      check("rst_no_broadcast", 64'(en_count), 64'd0);

      // mixed pattern of offers, stalls and a flush, checked by the model
      for (int k = 0; k < 40; k++) begin
         rs_valid  = (k % 3) != 0;
         lsb_valid = (k % 2) == 0;
         rdy_in    = (k % 5) != 4;
         flush     = (k == 23);
         rs_lab    = LAB_W'(k);       rs_val  = 32'hA000 + 32'(k);
         lsb_lab   = LAB_W'(k + 7);   lsb_val = 32'hB000 + 32'(k);
         cyc();
      end
      rs_valid = 1'b0; lsb_valid = 1'b0; rdy_in = 1'b1; flush = 1'b0;
      repeat (6) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
